// File: rtl/uart_tx_engine_if.sv
// Handshake and frame-config bundle between the UART register block (master)
// and the transmit serializer (slave).
interface uart_tx_engine_if;
  logic       start_tx;
  logic [7:0] tx_data;
  logic [1:0] data_bit_num;
  logic       stop_bit_num;
  logic       parity_en;
  logic       parity_type;
  logic       tx;
  logic       start_tx_down;
  logic       tx_done;
  logic       tx_busy;

  modport master (
    output start_tx, tx_data, data_bit_num, stop_bit_num, parity_en, parity_type,
    input  tx, start_tx_down, tx_done, tx_busy
  );

  modport slave (
    input  start_tx, tx_data, data_bit_num, stop_bit_num, parity_en, parity_type,
    output tx, start_tx_down, tx_done, tx_busy
  );
endinterface

// File: rtl/uart_tx_engine.sv
// UART transmit serializer: start bit, 5-8 data bits LSB first, optional parity,
// 1 or 2 stop bits. Every bit is held for BAUD_DIV clocks; all outputs registered.
module uart_tx_engine #(
  parameter int BAUD_DIV = 434
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_engine_if.slave  bus
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] baudCnt_q, baudCnt_d;
  logic [2:0]    bitCnt_q, bitCnt_d;
  logic          stopCnt_q, stopCnt_d;
  logic          tx_q, tx_d;
  logic          startTxDown_q, startTxDown_d;
  logic          txDone_q, txDone_d;
  logic          load;

  logic [7:0]    shadowData_q;
  logic [1:0]    shadowBits_q;
  logic          shadowStop_q;
  logic          shadowParEn_q;
  logic          shadowParType_q;

  logic [2:0]    lastBit;
  logic [7:0]    dataMask;
  logic          parityBit;

  // Only the captured copy of data/config is used, so mid-frame input changes are harmless.
  assign lastBit   = 3'd4 + {1'b0, shadowBits_q};
  assign dataMask  = 8'hFF >> (2'd3 - shadowBits_q);
  assign parityBit = (^(shadowData_q & dataMask)) ^ shadowParType_q;

  always_comb begin
    state_d       = state_q;
    baudCnt_d     = baudCnt_q;
    bitCnt_d      = bitCnt_q;
    stopCnt_d     = stopCnt_q;
    txDone_d      = txDone_q;
    startTxDown_d = 1'b0;
    load          = 1'b0;
    tx_d          = 1'b1;

    if (state_q == IDLE) begin
      if (bus.start_tx) begin
        load          = 1'b1;
        startTxDown_d = 1'b1;
        txDone_d      = 1'b0;
        state_d       = START;
        baudCnt_d     = '0;
      end
    end else if (baudCnt_q != BAUD_LAST) begin
      baudCnt_d = baudCnt_q + 1'b1;
    end else begin
      baudCnt_d = '0;
      unique case (state_q)
        START: begin
          state_d  = DATA;
          bitCnt_d = 3'd0;
        end
        DATA: begin
          if (bitCnt_q == lastBit) begin
            state_d   = shadowParEn_q ? PARITY : STOP;
            stopCnt_d = 1'b0;
          end else begin
            bitCnt_d = bitCnt_q + 3'd1;
          end
        end
        PARITY: begin
          state_d   = STOP;
          stopCnt_d = 1'b0;
        end
        STOP: begin
          if (stopCnt_q == shadowStop_q) begin
            state_d  = IDLE;
            txDone_d = 1'b1;
          end else begin
            stopCnt_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // The line level is computed from the next state so tx changes on the same edge as the state.
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shadowData_q[bitCnt_d];
      PARITY:  tx_d = parityBit;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      baudCnt_q       <= '0;
      bitCnt_q        <= 3'd0;
      stopCnt_q       <= 1'b0;
      tx_q            <= 1'b1;
      startTxDown_q   <= 1'b0;
      txDone_q        <= 1'b0;
      shadowData_q    <= 8'h00;
      shadowBits_q    <= 2'd0;
      shadowStop_q    <= 1'b0;
      shadowParEn_q   <= 1'b0;
      shadowParType_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      baudCnt_q     <= baudCnt_d;
      bitCnt_q      <= bitCnt_d;
      stopCnt_q     <= stopCnt_d;
      tx_q          <= tx_d;
      startTxDown_q <= startTxDown_d;
      txDone_q      <= txDone_d;
      if (load) begin
        shadowData_q    <= bus.tx_data;
        shadowBits_q    <= bus.data_bit_num;
        shadowStop_q    <= bus.stop_bit_num;
        shadowParEn_q   <= bus.parity_en;
        shadowParType_q <= bus.parity_type;
      end
    end
  end

  assign bus.tx            = tx_q;
  assign bus.start_tx_down = startTxDown_q;
  assign bus.tx_done       = txDone_q;
  assign bus.tx_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine at BAUD_DIV=4: table of frames with
// hand-derived line patterns, plus back-to-back, mid-frame change and reset cases.
module tb_uart_tx_engine;

  localparam int BD = 4;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  logic expQ[$];

  typedef struct {
    string      name;
    logic [7:0] data;
    logic [1:0] bits;
    logic       stop;
    logic       parEn;
    logic       parType;
    string      frame;
  } vec_t;

  vec_t vecs[7];

  uart_tx_engine_if bus();

  uart_tx_engine #(.BAUD_DIV(BD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t makeVec(input string n, input logic [7:0] d, input logic [1:0] b,
                                   input logic s, input logic pe, input logic pt, input string f);
    vec_t v;
    v.name = n; v.data = d; v.bits = b; v.stop = s; v.parEn = pe; v.parType = pt; v.frame = f;
    return v;
  endfunction

  task automatic checkBit(input string what, input logic act, input logic expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", what, act, expv, $time);
    end
  endtask

  // Drive the request and push the expected line pattern into the scoreboard.
  task automatic applyStimulus(input vec_t v);
    bus.tx_data      = v.data;
    bus.data_bit_num = v.bits;
    bus.stop_bit_num = v.stop;
    bus.parity_en    = v.parEn;
    bus.parity_type  = v.parType;
    bus.start_tx     = 1'b1;
    for (int i = 0; i < v.frame.len(); i++)
      expQ.push_back(v.frame[i] == 8'h31);
  endtask

  // Follow one frame from the accept edge to tx_done, popping each bit as it appears on tx.
  task automatic checkOutput(input string name, input int len, input bit hold, input bit scramble);
    logic expv;
    @(posedge clk);
    @(negedge clk);
    checkBit({name, " accept_pulse"}, bus.start_tx_down, 1'b1);
    checkBit({name, " done_cleared"}, bus.tx_done, 1'b0);
    if (!hold) bus.start_tx = 1'b0;
    if (scramble) begin
      bus.tx_data      = ~bus.tx_data;
      bus.data_bit_num = ~bus.data_bit_num;
      bus.stop_bit_num = ~bus.stop_bit_num;
      bus.parity_en    = ~bus.parity_en;
      bus.parity_type  = ~bus.parity_type;
    end
    for (int b = 0; b < len; b++) begin
      if (expQ.size() == 0) begin
        checkBit({name, " scoreboard_empty"}, 1'b1, 1'b0);
        expv = 1'b1;
      end else begin
        expv = expQ.pop_front();
      end
      for (int c = 0; c < BD; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        checkBit($sformatf("%s bit%0d cyc%0d", name, b, c), bus.tx, expv);
        if (hold && c == 1) checkBit({name, " no_pulse_busy"}, bus.start_tx_down, 1'b0);
      end
    end
    checkBit({name, " busy_last"}, bus.tx_busy, 1'b1);
    checkBit({name, " done_early"}, bus.tx_done, 1'b0);
    @(negedge clk);
    checkBit({name, " done_set"}, bus.tx_done, 1'b1);
    checkBit({name, " busy_clear"}, bus.tx_busy, 1'b0);
    checkBit({name, " idle_high"}, bus.tx, 1'b1);
    checkBit({name, " queue_drained"}, (expQ.size() == 0), 1'b1);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.start_tx = 1'b0;
    bus.tx_data = 8'h00;
    bus.data_bit_num = 2'd0;
    bus.stop_bit_num = 1'b0;
    bus.parity_en = 1'b0;
    bus.parity_type = 1'b0;

    vecs[0] = makeVec("8N1_A5", 8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, "0101001011");
    vecs[1] = makeVec("5E1_13", 8'h13, 2'b00, 1'b0, 1'b1, 1'b0, "01100111");
    vecs[2] = makeVec("7O2_FF", 8'hFF, 2'b10, 1'b1, 1'b1, 1'b1, "01111111011");
    vecs[3] = makeVec("6N1_2C", 8'h2C, 2'b01, 1'b0, 1'b0, 1'b0, "00011011");
    vecs[4] = makeVec("8O1_00", 8'h00, 2'b11, 1'b0, 1'b1, 1'b1, "00000000011");
    vecs[5] = makeVec("5O1_E0", 8'hE0, 2'b00, 1'b0, 1'b1, 1'b1, "00000011");
    vecs[6] = makeVec("8E2_7F", 8'h7F, 2'b11, 1'b1, 1'b1, 1'b0, "011111110111");

    repeat (3) @(negedge clk);
    checkBit("reset tx", bus.tx, 1'b1);
    checkBit("reset start_tx_down", bus.start_tx_down, 1'b0);
    checkBit("reset tx_done", bus.tx_done, 1'b0);
    checkBit("reset tx_busy", bus.tx_busy, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkBit("idle tx", bus.tx, 1'b1);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i].name, vecs[i].frame.len(), 1'b0, (i == 2 || i == 6));
      repeat (2) @(negedge clk);
      checkBit({vecs[i].name, " done_sticky"}, bus.tx_done, 1'b1);
    end

    // start_tx held high through a frame: second frame after one idle-high clock
    applyStimulus(vecs[0]);
    checkOutput("hold_first", vecs[0].frame.len(), 1'b1, 1'b0);
    applyStimulus(vecs[1]);
    checkOutput("hold_second", vecs[1].frame.len(), 1'b0, 1'b0);

    // Reset during data bit 3 of 0xA5 (that bit is 0, so the jump to 1 is visible)
    repeat (2) @(negedge clk);
    applyStimulus(vecs[0]);
    @(posedge clk);
    @(negedge clk);
    checkBit("rst_frame accept_pulse", bus.start_tx_down, 1'b1);
    bus.start_tx = 1'b0;
    repeat (4 * BD + 1) @(negedge clk);
    checkBit("rst_frame data_bit3", bus.tx, 1'b0);
    #2 rst = 1'b1;
    #1;
    checkBit("rst_async tx", bus.tx, 1'b1);
    checkBit("rst_async busy", bus.tx_busy, 1'b0);
    checkBit("rst_async done", bus.tx_done, 1'b0);
    expQ.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 12 * BD; c++) begin
      @(negedge clk);
      if (bus.tx !== 1'b1 || bus.tx_busy !== 1'b0) begin
        checkBit($sformatf("post_rst tx cyc%0d", c), bus.tx, 1'b1);
        checkBit($sformatf("post_rst busy cyc%0d", c), bus.tx_busy, 1'b0);
      end
    end
    checkBit("post_rst tx", bus.tx, 1'b1);
    checkBit("post_rst busy", bus.tx_busy, 1'b0);
    checkBit("post_rst done", bus.tx_done, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
